// File: rtl/spi_reg_if.sv
// SPI-slave / register-bus signal bundle for spi_reg_controller.
// The controller side uses the master modport (it drives the register
// strobes and the SPI transmit byte); the environment uses slave.
interface spi_reg_if #(
    parameter int ADDR_WIDTH = 7
);
    logic [7:0]            i_spi_data_rx;
    logic                  i_spi_ready;
    logic                  i_spi_busy;
    logic [7:0]            o_spi_data_tx;
    logic [ADDR_WIDTH-1:0] o_addr;
    logic [7:0]            o_wr_data;
    logic                  o_wr_en;
    logic                  o_rd_en;
    logic [7:0]            i_rd_data;
    logic                  o_frame_active;

    modport master (
        input  i_spi_data_rx,
        input  i_spi_ready,
        input  i_spi_busy,
        input  i_rd_data,
        output o_spi_data_tx,
        output o_addr,
        output o_wr_data,
        output o_wr_en,
        output o_rd_en,
        output o_frame_active
    );

    modport slave (
        output i_spi_data_rx,
        output i_spi_ready,
        output i_spi_busy,
        output i_rd_data,
        input  o_spi_data_tx,
        input  o_addr,
        input  o_wr_data,
        input  o_wr_en,
        input  o_rd_en,
        input  o_frame_active
    );
endinterface

// File: rtl/spi_reg_controller.sv
// SPI frame decoder: command byte {W/R, start address} followed by an
// unbounded burst of data bytes. Writes produce one-cycle write strobes
// with auto-increment; reads prefetch the next register so the SPI slave
// always has the following byte ready before it is shifted out.
// All outputs are registered; frames start only on a rising edge of busy.
module spi_reg_controller #(
    parameter int ADDR_WIDTH = 7
) (
    input  logic      i_clk,
    input  logic      i_rst,
    spi_reg_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_WR      = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_RD_DATA = 3'd5
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic                  busy_d_r;
    logic                  busy_rise_s;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [ADDR_WIDTH-1:0] addr_nxt_s;
    logic [ADDR_WIDTH-1:0] o_addr_r;
    logic [ADDR_WIDTH-1:0] o_addr_nxt_s;
    logic [7:0]            tx_r;
    logic [7:0]            tx_nxt_s;
    logic [7:0]            wr_data_r;
    logic [7:0]            wr_data_nxt_s;
    logic                  wr_en_r;
    logic                  wr_en_nxt_s;
    logic                  rd_en_r;
    logic                  rd_en_nxt_s;
    logic                  frame_r;
    logic                  frame_nxt_s;

    // busy_d resets high so a frame already running at reset release is
    // not mistaken for a new one.
    assign busy_rise_s = bus.i_spi_busy & ~busy_d_r;

    // State register and busy edge-detect flop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r  <= ST_IDLE;
            busy_d_r <= 1'b1;
        end else begin
            state_r  <= state_nxt_s;
            busy_d_r <= bus.i_spi_busy;
        end
    end

    // Next-state decode; busy low always ends the frame, after any ready
    // in the same cycle has been accounted for by the output logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (busy_rise_s) begin
                    state_nxt_s = ST_CMD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (!bus.i_spi_busy) begin
                    state_nxt_s = ST_IDLE;
                end else if (bus.i_spi_ready) begin
                    state_nxt_s = bus.i_spi_data_rx[7] ? ST_WR : ST_RD_REQ;
                end else begin
                    state_nxt_s = ST_CMD;
                end
            end
            ST_WR: begin
                if (!bus.i_spi_busy) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WR;
                end
            end
            ST_RD_REQ: begin
                if (!bus.i_spi_busy) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (!bus.i_spi_busy) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (!bus.i_spi_busy) begin
                    state_nxt_s = ST_IDLE;
                end else if (bus.i_spi_ready) begin
                    state_nxt_s = ST_RD_REQ;
                end else begin
                    state_nxt_s = ST_RD_DATA;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs and the running address.
    // Ready in RD_REQ/RD_WAIT is an overrun and is deliberately ignored.
    always_comb begin
        addr_nxt_s    = addr_r;
        o_addr_nxt_s  = o_addr_r;
        wr_en_nxt_s   = 1'b0;
        wr_data_nxt_s = wr_data_r;
        rd_en_nxt_s   = 1'b0;
        tx_nxt_s      = tx_r;
        frame_nxt_s   = (state_nxt_s != ST_IDLE);

        case (state_r)
            ST_CMD: begin
                if (bus.i_spi_ready) begin
                    addr_nxt_s = bus.i_spi_data_rx[ADDR_WIDTH-1:0];
                end else begin
                    addr_nxt_s = addr_r;
                end
            end
            ST_WR: begin
                if (bus.i_spi_ready) begin
                    wr_en_nxt_s   = 1'b1;
                    wr_data_nxt_s = bus.i_spi_data_rx;
                    o_addr_nxt_s  = addr_r;
                    addr_nxt_s    = addr_r + ADDR_WIDTH'(1);
                end else begin
                    addr_nxt_s = addr_r;
                end
            end
            ST_RD_DATA: begin
                if (bus.i_spi_ready) begin
                    addr_nxt_s = addr_r + ADDR_WIDTH'(1);
                end else begin
                    addr_nxt_s = addr_r;
                end
            end
            default: begin
                addr_nxt_s = addr_r;
            end
        endcase

        // The read strobe is issued on entry to RD_REQ so it is visible
        // during the whole RD_REQ cycle.
        if (state_nxt_s == ST_RD_REQ) begin
            rd_en_nxt_s  = 1'b1;
            o_addr_nxt_s = addr_nxt_s;
        end else begin
            rd_en_nxt_s = 1'b0;
        end

        if ((state_nxt_s == ST_IDLE) || (state_nxt_s == ST_CMD)) begin
            tx_nxt_s = 8'h00;
        end else if (state_r == ST_RD_WAIT) begin
            tx_nxt_s = bus.i_rd_data;
        end else begin
            tx_nxt_s = tx_r;
        end
    end

    // Output and address registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_r    <= {ADDR_WIDTH{1'b0}};
            o_addr_r  <= {ADDR_WIDTH{1'b0}};
            wr_en_r   <= 1'b0;
            wr_data_r <= 8'h00;
            rd_en_r   <= 1'b0;
            tx_r      <= 8'h00;
            frame_r   <= 1'b0;
        end else begin
            addr_r    <= addr_nxt_s;
            o_addr_r  <= o_addr_nxt_s;
            wr_en_r   <= wr_en_nxt_s;
            wr_data_r <= wr_data_nxt_s;
            rd_en_r   <= rd_en_nxt_s;
            tx_r      <= tx_nxt_s;
            frame_r   <= frame_nxt_s;
        end
    end

    assign bus.o_addr         = o_addr_r;
    assign bus.o_wr_en        = wr_en_r;
    assign bus.o_wr_data      = wr_data_r;
    assign bus.o_rd_en        = rd_en_r;
    assign bus.o_spi_data_tx  = tx_r;
    assign bus.o_frame_active = frame_r;

endmodule

// File: tb/tb_spi_reg_controller.sv
// Directed testbench for spi_reg_controller: write burst, read burst with
// prefetch and overrun, address wrap, abort, and reset mid-frame.
module tb_spi_reg_controller;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    spi_reg_if #(.ADDR_WIDTH(7)) bus ();

    spi_reg_controller #(.ADDR_WIDTH(7)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs set afterwards are sampled at the next edge
    // and outputs read afterwards reflect the edge just passed.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.i_spi_data_rx = b;
        bus.i_spi_ready   = 1'b1;
        tick();
        bus.i_spi_ready   = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.i_spi_data_rx = 8'h00;
        bus.i_spi_ready   = 1'b0;
        bus.i_spi_busy    = 1'b0;
        bus.i_rd_data     = 8'hEE;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_tx",    bus.o_spi_data_tx, 8'h00);
        chk("rst_addr",  {1'b0, bus.o_addr}, 8'h00);
        chk("rst_wdata", bus.o_wr_data, 8'h00);
        chk("rst_wr_en", {7'd0, bus.o_wr_en}, 8'h00);
        chk("rst_rd_en", {7'd0, bus.o_rd_en}, 8'h00);
        chk("rst_frame", {7'd0, bus.o_frame_active}, 8'h00);

        // Write burst: 0x85, 0xAA, 0xBB
        bus.i_spi_busy = 1'b1;
        tick();
        chk("wb_frame", {7'd0, bus.o_frame_active}, 8'h01);
        chk("wb_tx_cmd", bus.o_spi_data_tx, 8'h00);
        send(8'h85);
        chk("wb_no_wr_cmd", {7'd0, bus.o_wr_en}, 8'h00);
        send(8'hAA);
        chk("wb1_wr_en", {7'd0, bus.o_wr_en}, 8'h01);
        chk("wb1_addr",  {1'b0, bus.o_addr}, 8'h05);
        chk("wb1_data",  bus.o_wr_data, 8'hAA);
        chk("wb1_rd_en", {7'd0, bus.o_rd_en}, 8'h00);
        tick();
        chk("wb_wr_pulse", {7'd0, bus.o_wr_en}, 8'h00);
        send(8'hBB);
        chk("wb2_wr_en", {7'd0, bus.o_wr_en}, 8'h01);
        chk("wb2_addr",  {1'b0, bus.o_addr}, 8'h06);
        chk("wb2_data",  bus.o_wr_data, 8'hBB);
        chk("wb2_rd_en", {7'd0, bus.o_rd_en}, 8'h00);
        bus.i_spi_busy = 1'b0;
        tick();
        chk("wb_end_frame", {7'd0, bus.o_frame_active}, 8'h00);

        // Read burst: 0x10 then dummies; rd_data valid only the cycle after o_rd_en
        bus.i_spi_busy = 1'b1;
        tick();
        send(8'h10);
        chk("rb1_rd_en", {7'd0, bus.o_rd_en}, 8'h01);
        chk("rb1_addr",  {1'b0, bus.o_addr}, 8'h10);
        chk("rb1_wr_en", {7'd0, bus.o_wr_en}, 8'h00);
        tick();
        chk("rb1_rd_pulse", {7'd0, bus.o_rd_en}, 8'h00);
        bus.i_rd_data = 8'h3C;
        tick();
        bus.i_rd_data = 8'hEE;
        chk("rb1_tx", bus.o_spi_data_tx, 8'h3C);
        tick();
        chk("rb1_tx_hold", bus.o_spi_data_tx, 8'h3C);
        send(8'h00);
        chk("rb2_rd_en", {7'd0, bus.o_rd_en}, 8'h01);
        chk("rb2_addr",  {1'b0, bus.o_addr}, 8'h11);
        chk("rb2_tx_hold", bus.o_spi_data_tx, 8'h3C);
        tick();
        bus.i_rd_data = 8'h4D;
        tick();
        bus.i_rd_data = 8'hEE;
        chk("rb2_tx", bus.o_spi_data_tx, 8'h4D);
        send(8'h00);
        chk("rb3_addr", {1'b0, bus.o_addr}, 8'h12);
        // Overrun: ready while in RD_REQ is ignored
        send(8'h55);
        chk("ovr_rd_en", {7'd0, bus.o_rd_en}, 8'h00);
        chk("ovr_addr",  {1'b0, bus.o_addr}, 8'h12);
        bus.i_rd_data = 8'h5E;
        tick();
        bus.i_rd_data = 8'hEE;
        chk("ovr_tx", bus.o_spi_data_tx, 8'h5E);
        bus.i_spi_busy = 1'b0;
        tick();
        chk("rb_end_frame", {7'd0, bus.o_frame_active}, 8'h00);
        chk("rb_end_tx", bus.o_spi_data_tx, 8'h00);

        // Address wrap; last byte arrives together with busy falling
        bus.i_spi_busy = 1'b1;
        tick();
        send(8'hFF);
        send(8'h01);
        chk("wrap1_wr_en", {7'd0, bus.o_wr_en}, 8'h01);
        chk("wrap1_addr",  {1'b0, bus.o_addr}, 8'h7F);
        chk("wrap1_data",  bus.o_wr_data, 8'h01);
        bus.i_spi_busy = 1'b0;
        send(8'h02);
        chk("wrap2_wr_en", {7'd0, bus.o_wr_en}, 8'h01);
        chk("wrap2_addr",  {1'b0, bus.o_addr}, 8'h00);
        chk("wrap2_data",  bus.o_wr_data, 8'h02);
        chk("wrap2_frame", {7'd0, bus.o_frame_active}, 8'h00);
        tick();
        chk("wrap_wr_pulse", {7'd0, bus.o_wr_en}, 8'h00);

        // Abort after read command, then a fresh write frame
        bus.i_spi_busy = 1'b1;
        tick();
        send(8'h20);
        chk("ab_rd_en", {7'd0, bus.o_rd_en}, 8'h01);
        chk("ab_addr",  {1'b0, bus.o_addr}, 8'h20);
        bus.i_spi_busy = 1'b0;
        tick();
        chk("ab_frame", {7'd0, bus.o_frame_active}, 8'h00);
        chk("ab_rd_off", {7'd0, bus.o_rd_en}, 8'h00);
        tick();
        chk("ab_rd_quiet", {7'd0, bus.o_rd_en}, 8'h00);
        chk("ab_tx", bus.o_spi_data_tx, 8'h00);
        bus.i_spi_busy = 1'b1;
        tick();
        send(8'h83);
        send(8'h44);
        chk("ab2_wr_en", {7'd0, bus.o_wr_en}, 8'h01);
        chk("ab2_addr",  {1'b0, bus.o_addr}, 8'h03);
        chk("ab2_data",  bus.o_wr_data, 8'h44);
        chk("ab2_rd_en", {7'd0, bus.o_rd_en}, 8'h00);
        bus.i_spi_busy = 1'b0;
        tick();

        // Reset mid-frame with busy held high
        bus.i_spi_busy = 1'b1;
        tick();
        send(8'h81);
        bus.i_spi_data_rx = 8'h99;
        bus.i_spi_ready   = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.i_spi_ready = 1'b0;
        chk("mr_wr_en", {7'd0, bus.o_wr_en}, 8'h00);
        chk("mr_addr",  {1'b0, bus.o_addr}, 8'h00);
        tick();
        chk("mr_frame", {7'd0, bus.o_frame_active}, 8'h00);
        send(8'h85);
        send(8'h11);
        chk("mr_no_wr", {7'd0, bus.o_wr_en}, 8'h00);
        chk("mr_no_frame", {7'd0, bus.o_frame_active}, 8'h00);
        bus.i_spi_busy = 1'b0;
        tick();
        bus.i_spi_busy = 1'b1;
        tick();
        chk("mr2_frame", {7'd0, bus.o_frame_active}, 8'h01);
        send(8'h82);
        send(8'h11);
        chk("mr2_wr_en", {7'd0, bus.o_wr_en}, 8'h01);
        chk("mr2_addr",  {1'b0, bus.o_addr}, 8'h02);
        chk("mr2_data",  bus.o_wr_data, 8'h11);
        bus.i_spi_busy = 1'b0;
        tick();
        chk("mr2_end_frame", {7'd0, bus.o_frame_active}, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_reg_controller.md
SPI_REG_CONTROLLER -- requirements
Module: spi_reg_controller

Interface
REQ-001 Parameter: ADDR_WIDTH, 7, register address width; the command byte carries it in bits [ADDR_WIDTH-1:0], so ADDR_WIDTH SHALL be 7.
REQ-002 Port: i_clk  in  1  fpga clock; all logic on its rising edge.
REQ-003 Port: i_rst  in  1  reset, synchronous, active-high.
REQ-004 Port: i_spi_data_rx  in  8  byte received from the SPI slave.
REQ-005 Port: i_spi_ready  in  1  one-cycle pulse; i_spi_data_rx valid.
REQ-006 Port: i_spi_busy  in  1  high while slave select is active (frame in progress).
REQ-007 Port: o_spi_data_tx  out  8  byte the SPI slave shifts out on the next transfer.
REQ-008 Port: o_addr  out  ADDR_WIDTH  register address for write/read strobes.
REQ-009 Port: o_wr_data  out  8  write data; valid while o_wr_en is high.
REQ-010 Port: o_wr_en  out  1  one-cycle write strobe.
REQ-011 Port: o_rd_en  out  1  one-cycle read strobe.
REQ-012 Port: i_rd_data  in  8  read data; valid the cycle after o_rd_en.
REQ-013 Port: o_frame_active  out  1  high in every state except IDLE.

Function
REQ-014 Frame format: first byte = command {bit7 W/R (1=write), bits[6:0] start address}; following bytes = data; burst length unbounded.
REQ-015 The block SHALL register i_spi_busy into busy_d and SHALL start a frame only on a rising edge (busy_d=0, i_spi_busy=1).
REQ-016 States SHALL be IDLE, CMD, WR, RD_REQ, RD_WAIT and RD_DATA.
REQ-017 IDLE: on busy rising edge -> CMD; o_spi_data_tx SHALL be 0x00 in IDLE and CMD.
REQ-018 CMD: on i_spi_ready, latch address = rx[6:0]; rx[7]=1 -> WR; rx[7]=0 -> RD_REQ.
REQ-019 WR: an i_spi_ready at cycle T SHALL give o_wr_en=1 at T+1 with o_addr=current address and o_wr_data=rx byte; the address increments after the strobe.
REQ-020 RD_REQ: o_rd_en=1 for exactly one cycle with o_addr=current address; -> RD_WAIT.
REQ-021 RD_WAIT: sample i_rd_data into o_spi_data_tx; -> RD_DATA.
REQ-022 Read latency: command byte ready at T -> o_rd_en at T+1 -> o_spi_data_tx updated at T+3.
REQ-023 RD_DATA: on i_spi_ready (byte shifted out), increment address and go to RD_REQ (prefetch); o_spi_data_tx holds until then.
REQ-024 Address arithmetic SHALL be modulo 2^ADDR_WIDTH; 0x7F+1 = 0x00.
REQ-025 i_spi_busy low in any non-IDLE state -> IDLE next cycle, with no further strobes; a pending o_wr_en from a ready in the prior cycle still completes.
REQ-026 i_spi_ready with i_spi_busy low in the same cycle: process the ready first, then return to IDLE.
REQ-027 i_spi_ready in RD_REQ or RD_WAIT (overrun) SHALL be ignored; the sequence continues unchanged.
REQ-028 The block SHALL issue at most one strobe (o_wr_en or o_rd_en) per cycle, and never both.

Reset
REQ-029 On i_rst: state=IDLE, o_spi_data_tx=0x00, o_addr=0, o_wr_data=0x00, o_wr_en=0, o_rd_en=0, o_frame_active=0.
REQ-030 On i_rst, busy_d SHALL reset to 1, so a frame already in progress at reset release is ignored until i_spi_busy goes low then high.
REQ-031 Reset asserted mid-burst SHALL suppress all strobes from the following cycle onward.

Verification
REQ-032 Write burst: busy high; bytes 0x85, 0xAA, 0xBB -> o_wr_en pulses at addr 0x05 data 0xAA, then addr 0x06 data 0xBB; no o_rd_en.
REQ-033 Read burst: bytes 0x10 then 2 dummies; i_rd_data=0x3C@0x10, 0x4D@0x11 -> o_rd_en at T+1 addr 0x10; o_spi_data_tx=0x3C at T+3; after dummy 1, prefetch addr 0x11 -> 0x4D.
REQ-034 Wrap: write command 0xFF, data 0x01, 0x02 -> writes at addr 0x7F then 0x00.
REQ-035 Abort: busy falls after the command byte in read mode -> IDLE, o_frame_active=0; the next frame's command is decoded fresh.
REQ-036 Reset mid-frame with busy held high: further bytes produce no strobes; after busy low then high, command 0x82 plus data 0x11 -> write addr 0x02 data 0x11.
